// File: rtl/img_coproc_pkg.sv
// img_coproc_pkg: shared types, default geometry and counter sizing for the image coprocessor
package img_coproc_pkg;
   localparam int FILTER_W = 3;
   localparam int PIX_W = 12;
   localparam int IMG_W = 256;
   localparam int IMG_H = 384;
   localparam int ROW_GAP = 2;
   localparam int TIMEOUT = 64;
   typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, DONE, ABORT} sched_state_t;
   function automatic int cnt_w(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction
endpackage

// File: rtl/img_conv_sched_if.sv
// img_conv_sched_if: CPU command, convolution and DMA signals of the frame scheduler
interface img_conv_sched_if #(parameter int PIX_W = img_coproc_pkg::PIX_W);
   import img_coproc_pkg::*;
   logic cmd_valid, cmd_ready, cmd_abort, irq_clr, busy, done, irq, err;
   logic dma_start, conv_en, conv_valid, dma_we;
   logic [FILTER_W-1:0] cmd_filter, filter_sel;
   logic [PIX_W-1:0] conv_data, dma_wdata;
   modport slave (
      input cmd_valid, cmd_filter, cmd_abort, irq_clr, conv_valid, conv_data,
      output cmd_ready, busy, done, irq, err, filter_sel, dma_start, conv_en, dma_we, dma_wdata
   );
   modport master (
      output cmd_valid, cmd_filter, cmd_abort, irq_clr, conv_valid, conv_data,
      input cmd_ready, busy, done, irq, err, filter_sel, dma_start, conv_en, dma_we, dma_wdata
   );
endinterface

// File: rtl/img_issue_cnt.sv
// img_issue_cnt: column/row/gap pacing of pixel issue; counters idle at zero whenever run is low
module img_issue_cnt #(
   parameter int IMG_W = img_coproc_pkg::IMG_W,
   parameter int IMG_H = img_coproc_pkg::IMG_H,
   parameter int ROW_GAP = img_coproc_pkg::ROW_GAP
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic issue_en,
   output logic last_issue
);
   import img_coproc_pkg::*;
   localparam int CW = cnt_w(IMG_W);
   localparam int RW = cnt_w(IMG_H);
   localparam int GW = cnt_w(ROW_GAP + 1);
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [GW-1:0] gap;
   logic col_end, row_end;
   always_comb begin
      col_end = col == CW'(IMG_W - 1);
      row_end = row == RW'(IMG_H - 1);
      issue_en = run && gap == '0;
      last_issue = issue_en && col_end && row_end;
   end
   always_ff @(posedge clk) begin
      if (!rst_n || !run) begin
         col <= '0;
         row <= '0;
         gap <= '0;
      end else if (gap != '0) begin
         gap <= gap - GW'(1);
      end else if (col_end) begin
         col <= '0;
         row <= row_end ? row : row + RW'(1);
         gap <= row_end ? '0 : GW'(ROW_GAP);
      end else begin
         col <= col + CW'(1);
      end
   end
endmodule

// File: rtl/img_conv_sched.sv
// img_conv_sched: frame scheduler sequencing DMA start, pixel issue, result forwarding and completion/watchdog
module img_conv_sched #(
   parameter int IMG_W = img_coproc_pkg::IMG_W,
   parameter int IMG_H = img_coproc_pkg::IMG_H,
   parameter int ROW_GAP = img_coproc_pkg::ROW_GAP,
   parameter int TIMEOUT = img_coproc_pkg::TIMEOUT
) (
   input logic clk,
   input logic rst_n,
   img_conv_sched_if.slave bus
);
   import img_coproc_pkg::*;
   localparam int TOTAL = IMG_W * IMG_H;
   localparam int RCW = $clog2(TOTAL + 1);
   localparam int WDW = $clog2(TIMEOUT + 1);
   sched_state_t state, nxt;
   logic [RCW-1:0] res_cnt;
   logic [WDW-1:0] wd;
   logic issue_en, last_issue, in_rd, res_full, accept, timeout;
   img_issue_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ROW_GAP(ROW_GAP)) u_issue (
      .clk(clk),
      .rst_n(rst_n),
      .run(state == RUN),
      .issue_en(issue_en),
      .last_issue(last_issue)
   );
   always_comb begin
      in_rd = state == RUN || state == DRAIN;
      res_full = res_cnt == RCW'(TOTAL);
      // an abort in the same cycle as a result discards that result
      accept = in_rd && bus.conv_valid && !res_full && !bus.cmd_abort;
      timeout = state == DRAIN && !bus.conv_valid && !res_full && wd == WDW'(TIMEOUT - 1);
      nxt = state;
      case (state)
         IDLE:    nxt = bus.cmd_valid ? START : IDLE;
         START:   nxt = bus.cmd_abort ? ABORT : RUN;
         RUN:     nxt = bus.cmd_abort ? ABORT : last_issue ? DRAIN : RUN;
         DRAIN:   nxt = (bus.cmd_abort || timeout) ? ABORT : res_full ? DONE : DRAIN;
         default: nxt = IDLE;
      endcase
      bus.cmd_ready = state == IDLE;
      bus.busy = state != IDLE;
      bus.done = state == DONE;
      bus.dma_start = state == START;
      bus.conv_en = issue_en;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         res_cnt <= '0;
         wd <= '0;
         bus.irq <= 1'b0;
         bus.err <= 1'b0;
         bus.filter_sel <= '0;
         bus.dma_we <= 1'b0;
         bus.dma_wdata <= '0;
      end else begin
         state <= nxt;
         res_cnt <= in_rd ? res_cnt + RCW'(accept) : '0;
         wd <= (state != DRAIN || bus.conv_valid || res_full) ? '0 : wd + WDW'(1);
         bus.irq <= state == DONE || timeout || (bus.irq && !bus.irq_clr);
         bus.err <= timeout || (bus.err && !bus.irq_clr);
         if (state == IDLE && bus.cmd_valid) bus.filter_sel <= bus.cmd_filter;
         bus.dma_we <= accept;
         bus.dma_wdata <= bus.conv_data;
      end
   end
endmodule
